cpu_sequencer: RTL

//  Fetch/decode/execute/write-back controller sitting directly upstream of the
//  8-bit ALU and its control unit. Fetches 20-bit instructions over a

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/cpu_regfile_4x8.sv | 29 ++
 rtl/cpu_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the sequencer: instruction layout, opcodes, FSM states.
package cpu_pkg;
    localparam int INSTR_W = 20;
    localparam int DATA_W  = 8;
    localparam int NREG    = 4;
    localparam int RIDX_W  = 2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_DIV = 3'd6;
    localparam logic [2:0] OP_CMP = 3'd7;

    // [19] rsvd, [18:16] op, [15] halt, [14] imm_sel, [13:12] rd, [11:10] rs, [9:8] rsvd, [7:0] imm8
    localparam int OP_LSB   = 16;
    localparam int HALT_BIT = 15;
    localparam int IMM_BIT  = 14;
    localparam int RD_LSB   = 12;
    localparam int RS_LSB   = 10;
    localparam int IMM_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    function automatic logic [RIDX_W-1:0] f_rd(input logic [INSTR_W-1:0] ir);
        return ir[RD_LSB +: RIDX_W];
    endfunction

    function automatic logic [RIDX_W-1:0] f_rs(input logic [INSTR_W-1:0] ir);
        return ir[RS_LSB +: RIDX_W];
    endfunction
endpackage

// File: rtl/cpu_regfile_4x8.sv
// 4x8 register file: two async read ports, a debug read port, one sync write port.
module cpu_regfile_4x8
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [RIDX_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [RIDX_W-1:0] i_raddr_a,
    output logic [DATA_W-1:0] o_rdata_a,
    input  logic [RIDX_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_b,
    input  logic [RIDX_W-1:0] i_dbg_sel,
    output logic [DATA_W-1:0] o_dbg_rdata
);
    logic [NREG-1:0][DATA_W-1:0] r_mem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mem <= '0;
        else if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata_a   = r_mem[i_raddr_a];
    assign o_rdata_b   = r_mem[i_raddr_b];
    assign o_dbg_rdata = r_mem[i_dbg_sel];
endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute/write-back controller driving an external 8-bit ALU.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [2:0]         alu_opcode,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic               alu_carry,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               done,
    output logic               flag_c,
    output logic               flag_z,
    input  logic [RIDX_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_rdata
);
    state_e               r_state, w_next;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_ir;
    logic [2:0]           r_opcode;
    logic [DATA_W-1:0]    r_alu_a, r_alu_b;
    logic                 r_flag_c, r_flag_z;
    logic [DATA_W-1:0]    w_rd_data, w_rs_data;
    logic                 w_we;
    logic                 w_unused_ir;

    assign w_we        = (r_state == ST_WB);
    assign w_unused_ir = ^{r_ir[INSTR_W-1], r_ir[9:8]};

    cpu_regfile_4x8 u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_we        (w_we),
        .i_waddr     (f_rd(r_ir)),
        .i_wdata     (alu_result),
        .i_raddr_a   (f_rd(r_ir)),
        .o_rdata_a   (w_rd_data),
        .i_raddr_b   (f_rs(r_ir)),
        .o_rdata_b   (w_rs_data),
        .i_dbg_sel   (dbg_sel),
        .o_dbg_rdata (dbg_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_HALTED: if (start) w_next = ST_FETCH;
            ST_FETCH:           if (imem_valid) w_next = ST_DECODE;
            ST_DECODE:          w_next = r_ir[HALT_BIT] ? ST_HALTED : ST_EXEC;
            ST_EXEC:            w_next = ST_WB;
            ST_WB:              w_next = ST_FETCH;
            default:            w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_req = (r_state == ST_FETCH);
        busy     = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                   (r_state == ST_EXEC)  || (r_state == ST_WB);
        done     = (r_state == ST_HALTED);
    end

    // Operands load in DECODE, opcode one cycle later in EXEC, so the ALU inputs
    // are settled before the control unit sees the new opcode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= START_ADDR;
            r_ir     <= '0;
            r_opcode <= OP_ADD;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_HALTED: if (start) r_pc <= START_ADDR;
                ST_FETCH:           if (imem_valid) r_ir <= imem_rdata;
                ST_DECODE: begin
                    r_alu_a <= w_rd_data;
                    r_alu_b <= r_ir[IMM_BIT] ? r_ir[IMM_LSB +: DATA_W] : w_rs_data;
                end
                ST_EXEC:            r_opcode <= r_ir[OP_LSB +: 3];
                ST_WB: begin
                    r_flag_c <= alu_carry;
                    r_flag_z <= (alu_result == '0);
                    r_pc     <= r_pc + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign alu_opcode = r_opcode;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign flag_c     = r_flag_c;
    assign flag_z     = r_flag_z;
endmodule
